sub_bytes_seq128: RTL and testbench

//  Forward AES SubBytes engine for a 128-bit state. It is the encrypt-side counterpart of the inverse-SubBytes datapath.

---
 rtl/sub_bytes_seq128_pkg.sv | 54 +++++
 rtl/sub_bytes_seq128_if.sv | 28 ++
 rtl/sub_bytes_seq128_sbox.sv | 21 ++
 rtl/sub_bytes_seq128.sv | 135 +++++++++++++
 tb/tb_sub_bytes_seq128.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sub_bytes_seq128_pkg.sv
// Shared AES definitions for the sequential SubBytes engine: block/byte
// widths, FSM state encoding and the forward/inverse S-box tables.
// Build option: SUB_BYTES_INV_EN (inverse table is used only when defined).
package aes_pkg;

    localparam int AES_BLK_W   = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_BLK_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_t;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_seq128_if.sv
// Block-level handshake bundle for the SubBytes engine: an input channel
// (valid/ready/data), an output channel (valid/ready/data) and a busy flag.
// Build option: SUB_BYTES_INV_EN adds the per-block inverse-mode select inv_i.
interface sub_bytes_seq128_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_data;
    logic                 busy;
`ifdef SUB_BYTES_INV_EN
    logic                 inv_i;

    modport master (output in_valid, in_data, out_ready, inv_i,
                    input  in_ready, out_valid, out_data, busy);
    modport slave  (input  in_valid, in_data, out_ready, inv_i,
                    output in_ready, out_valid, out_data, busy);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, busy);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, busy);
`endif

endinterface

// File: rtl/sub_bytes_seq128_sbox.sv
// Single-byte AES S-box lookup, purely combinational. INV selects which
// table this instance carries, so a forward-only build never contains
// the inverse table.
module aes_sbox8
    import aes_pkg::*;
#(
    parameter bit INV = 1'b0
) (
    input  logic [AES_BYTE_W-1:0] x,
    output logic [AES_BYTE_W-1:0] y
);

    generate
        if (INV) begin : g_inv
            assign y = SBOX_INV[x];
        end else begin : g_fwd
            assign y = SBOX_FWD[x];
        end
    endgenerate

endmodule

// File: rtl/sub_bytes_seq128.sv
// Sequential AES SubBytes engine: accepts a 128-bit state, substitutes
// LANES bytes per clock (byte 0 = MSB first) and presents the result
// until the downstream handshake completes.
// Build option: SUB_BYTES_INV_EN adds inv_i and a parallel inverse S-box
// per lane; the mode is latched on the accept edge for the whole block.
module sub_bytes_seq128
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    sub_bytes_seq128_if.slave  bus
);

    localparam int N_BEATS = AES_NBYTES / LANES;
    localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_BEATS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq128: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sb_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AES_BYTE_W-1:0] work_q [AES_NBYTES];
    logic [AES_BYTE_W-1:0] work_d [AES_NBYTES];
    logic [AES_BLK_W-1:0]  out_data_q, out_data_d;
    logic                  inv_q, inv_d;

    logic [AES_BYTE_W-1:0] in_bytes  [AES_NBYTES];
    logic [AES_BYTE_W-1:0] run_bytes [AES_NBYTES];
    logic [AES_BLK_W-1:0]  run_packed;
    logic [3:0]            base_idx;
    logic [AES_BYTE_W-1:0] sbox_x [LANES];
    logic [AES_BYTE_W-1:0] sbox_y [LANES];
    logic                  mode_in;

`ifdef SUB_BYTES_INV_EN
    assign mode_in = bus.inv_i;
`else
    assign mode_in = 1'b0;
`endif

    // First byte of the group handled in the current beat.
    assign base_idx = 4'(int'(cnt_q) * LANES);

    // Lane datapath: read the current group from the work register and substitute.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [AES_BYTE_W-1:0] fwd_y;

            assign sbox_x[gi] = work_q[base_idx + 4'(gi)];

            aes_sbox8 #(.INV(1'b0)) u_sbox_fwd (.x(sbox_x[gi]), .y(fwd_y));

`ifdef SUB_BYTES_INV_EN
            logic [AES_BYTE_W-1:0] inv_y;
            aes_sbox8 #(.INV(1'b1)) u_sbox_inv (.x(sbox_x[gi]), .y(inv_y));
            assign sbox_y[gi] = inv_q ? inv_y : fwd_y;
`else
            assign sbox_y[gi] = fwd_y;
`endif
        end
    endgenerate

    // Byte view of the input, and the work register after this beat's writeback.
    // Byte k belongs to beat k/LANES and lane k%LANES, so the demux is static.
    generate
        for (genvar gi = 0; gi < AES_NBYTES; gi++) begin : g_byte
            assign in_bytes[gi]  = bus.in_data[AES_BLK_W-1-AES_BYTE_W*gi -: AES_BYTE_W];
            assign run_bytes[gi] = (cnt_q == CW'(gi / LANES)) ? sbox_y[gi % LANES] : work_q[gi];
            assign run_packed[AES_BLK_W-1-AES_BYTE_W*gi -: AES_BYTE_W] = run_bytes[gi];
        end
    endgenerate

    // Next-state logic: accept in IDLE, one beat per cycle in RUN, hold in DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        inv_d      = inv_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    work_d  = in_bytes;
                    inv_d   = mode_in;
                end
            end
            RUN: begin
                work_d = run_bytes;
                if (cnt_q == LAST_BEAT) begin
                    state_d    = DONE;
                    out_data_d = run_packed;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, work and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '{default: '0};
            out_data_q <= '0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            out_data_q <= out_data_d;
            inv_q      <= inv_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_sub_bytes_seq128.sv
// Directed bench for sub_bytes_seq128 at LANES = 4, 1 and 16. Expected
// blocks go into a scoreboard queue at accept time and are popped when
// out_valid appears. The reference S-box is computed arithmetically
// (GF(2^8) inverse plus affine map) rather than taken from the RTL table.
module tb_sub_bytes_seq128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam int NDUT = 3;
    int lanes_of [NDUT] = '{4, 1, 16};

    logic         in_valid_a  [NDUT];
    logic [127:0] in_data_a   [NDUT];
    logic         out_ready_a [NDUT];
    logic         in_ready_a  [NDUT];
    logic         out_valid_a [NDUT];
    logic         busy_a      [NDUT];
    logic [127:0] out_data_a  [NDUT];
`ifdef SUB_BYTES_INV_EN
    logic         inv_a       [NDUT];
`endif

    sub_bytes_seq128_if bus_if [NDUT] ();

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int LN = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
            assign bus_if[gi].in_valid  = in_valid_a[gi];
            assign bus_if[gi].in_data   = in_data_a[gi];
            assign bus_if[gi].out_ready = out_ready_a[gi];
`ifdef SUB_BYTES_INV_EN
            assign bus_if[gi].inv_i     = inv_a[gi];
`endif
            assign in_ready_a[gi]  = bus_if[gi].in_ready;
            assign out_valid_a[gi] = bus_if[gi].out_valid;
            assign busy_a[gi]      = bus_if[gi].busy;
            assign out_data_a[gi]  = bus_if[gi].out_data;

            sub_bytes_seq128 #(.LANES(LN)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus_if[gi])
            );
        end
    endgenerate

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    logic [127:0] exp_q [$];
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);   // x^254 = x^-1, 0 -> 0
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_blk(logic [127:0] d, bit inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = inv ? inv_t[d[127-8*k -: 8]] : fwd_t[d[127-8*k -: 8]];
        end
        return r;
    endfunction

    task automatic check(string tag, logic [135:0] obs, logic [135:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, measure latency, optional backpressure, output handshake.
    task automatic run_block(int d, logic [127:0] din, logic [127:0] exp, bit inv, bit toggle,
                             int hold, string tag);
        int lat;
        logic [127:0] got;
        logic [127:0] want;
        @(negedge clk);
        check({tag, " in_ready"}, 136'(in_ready_a[d]), 136'(1));
        in_valid_a[d]  = 1'b1;
        in_data_a[d]   = din;
        out_ready_a[d] = 1'b0;
`ifdef SUB_BYTES_INV_EN
        inv_a[d] = inv;
`endif
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid_a[d] = 1'b0;
        in_data_a[d]  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (lat < 40) begin
`ifdef SUB_BYTES_INV_EN
            if (toggle) inv_a[d] = ~inv_a[d];
`endif
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid_a[d]) break;
        end
        check({tag, " latency"}, 136'(lat), 136'(16 / lanes_of[d]));
        check({tag, " busy/in_ready in DONE"}, 136'({busy_a[d], in_ready_a[d]}), 136'(2'b10));
        got  = out_data_a[d];
        want = exp_q.pop_front();
        check({tag, " data"}, 136'(got), 136'(want));
        $display("blk %s dut%0d lanes=%0d in=%h out=%h lat=%0d", tag, d, lanes_of[d], din, got, lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, {6'd0, out_valid_a[d], in_ready_a[d], got}, {6'd0, 1'b1, 1'b0, want});
        end
        out_ready_a[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[d] = 1'b0;
        @(negedge clk);
        check({tag, " back to idle"}, 136'({out_valid_a[d], in_ready_a[d], busy_a[d]}), 136'(3'b010));
        repeat (3) @(negedge clk);
        check({tag, " one block only"}, 136'(out_valid_a[d]), 136'(0));
    endtask

    initial begin
        int hi;
        for (int i = 0; i < 256; i++) fwd_t[i] = sbox_model(8'(i));
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_a[d] = 1'b0; in_data_a[d] = '0; out_ready_a[d] = 1'b0;
`ifdef SUB_BYTES_INV_EN
            inv_a[d] = 1'b0;
`endif
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset state", {5'd0, out_valid_a[d], busy_a[d], in_ready_a[d], out_data_a[d]},
                  {5'd0, 1'b0, 1'b0, 1'b1, 128'd0});
        end

        run_block(0, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, 0, 0, 0, "seq");
        run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 0, 0, 10, "fips");
        run_block(0, {16{8'h00}}, {16{8'h63}}, 0, 0, 0, "all00");
        run_block(0, {16{8'hff}}, {16{8'h16}}, 0, 0, 0, "allff");
        run_block(0, {16{8'h53}}, {16{8'hed}}, 0, 0, 0, "all53");
        for (int i = 0; i < 3; i++) begin
            logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
            run_block(0, r, sub_blk(r, 0), 0, 0, 0, "rand");
        end

        // Reset mid-RUN: block is dropped and outputs return to reset values.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        @(negedge clk);
        check("rst busy before", 136'(busy_a[0]), 136'(1));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst mid-run", {5'd0, out_valid_a[0], busy_a[0], in_ready_a[0], out_data_a[0]},
              {5'd0, 1'b0, 1'b0, 1'b1, 128'd0});
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_a[0] || busy_a[0]) hi++;
        end
        check("rst discard", 136'(hi), 136'(0));

        for (int d = 1; d < NDUT; d++) begin
            run_block(d, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, 0, 0, 0, "seq");
            run_block(d, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 0, 0, 2, "fips");
            run_block(d, {16{8'h00}}, {16{8'h63}}, 0, 0, 0, "all00");
            run_block(d, {16{8'hff}}, {16{8'h16}}, 0, 0, 0, "allff");
            run_block(d, {16{8'h53}}, {16{8'hed}}, 0, 0, 0, "all53");
        end

`ifdef SUB_BYTES_INV_EN
        for (int d = 0; d < NDUT; d++) begin
            run_block(d, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1, 1, 0, "inv");
            run_block(d, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, 1, 0, 0, "invseq");
            begin
                logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
                run_block(d, r, sub_blk(r, 0), 0, 1, 0, "fwdtoggle");
                run_block(d, r, sub_blk(r, 1), 1, 0, 0, "invrand");
            end
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
